// File: rtl/pad_in_debounce.sv
// Pad input conditioner: synchronises an asynchronous pad level, commits a new level only after
// DEBOUNCE_CYCLES consecutive equal samples, emits edge strobes and counts rejected glitches.
module pad_in_debounce #(
   parameter int   SYNC_STAGES     = 2,
   parameter int   CNT_W           = 16,
   parameter int   DEBOUNCE_CYCLES = 1000,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pad_in,
   input  logic       glitch_clr,
   output logic       level_out,
   output logic       rise_pulse,
   output logic       fall_pulse,
   output logic [7:0] glitch_cnt
);

   // state      | meaning
   // STABLE_LO  | committed level 0, synchronised input also 0
   // CHK_HI     | committed level 0, counting consecutive 1 samples
   // STABLE_HI  | committed level 1, synchronised input also 1
   // CHK_LO     | committed level 1, counting consecutive 0 samples
   localparam logic [1:0] ST_STABLE_LO = 2'd0;
   localparam logic [1:0] ST_CHK_HI    = 2'd1;
   localparam logic [1:0] ST_STABLE_HI = 2'd2;
   localparam logic [1:0] ST_CHK_LO    = 2'd3;

   localparam logic [1:0]             ST_RESET = RESET_LEVEL ? ST_STABLE_HI : ST_STABLE_LO;
   localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
   localparam logic [SYNC_STAGES-1:0] SYNC_RST = {SYNC_STAGES{RESET_LEVEL}};

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic [7:0]       gcnt_q, gcnt_d;
   logic             glitch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= SYNC_RST;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      glitch  = 1'b0;
      case (state_q)
         ST_STABLE_LO: begin
            if (s) begin
               state_d = ST_CHK_HI;
               cnt_d   = CNT_ONE;
            end
         end
         ST_CHK_HI: begin
            if (!s) begin
               state_d = ST_STABLE_LO;
               cnt_d   = '0;
               glitch  = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_STABLE_HI;
               cnt_d   = '0;
               level_d = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_STABLE_HI: begin
            if (!s) begin
               state_d = ST_CHK_LO;
               cnt_d   = CNT_ONE;
            end
         end
         ST_CHK_LO: begin
            if (s) begin
               state_d = ST_STABLE_HI;
               cnt_d   = '0;
               glitch  = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_STABLE_LO;
               cnt_d   = '0;
               level_d = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_RESET;
            cnt_d   = '0;
         end
      endcase
   end

   // A clear in the same cycle as a rejected pulse takes priority.
   always_comb begin
      gcnt_d = gcnt_q;
      if (glitch_clr) begin
         gcnt_d = 8'd0;
      end else if (glitch && (gcnt_q != 8'hFF)) begin
         gcnt_d = gcnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RESET;
         cnt_q   <= '0;
         level_q <= RESET_LEVEL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         gcnt_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         gcnt_q  <= gcnt_d;
      end
   end

   assign level_out  = level_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign glitch_cnt = gcnt_q;

endmodule

// File: tb/tb_pad_in_debounce.sv
// Bench for pad_in_debounce: directed scenarios plus random pad activity, all checked against a
// run-length reference model of the debounce rules.
module tb_pad_in_debounce;

   localparam int SYNC = 2;
   localparam int DEB  = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pad_in;
   logic       glitch_clr;
   logic       level_out;
   logic       rise_pulse;
   logic       fall_pulse;
   logic [7:0] glitch_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   pad_in_debounce #(
      .SYNC_STAGES    (SYNC),
      .CNT_W          (16),
      .DEBOUNCE_CYCLES(DEB),
      .RESET_LEVEL    (1'b0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pad_in    (pad_in),
      .glitch_clr(glitch_clr),
      .level_out (level_out),
      .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse),
      .glitch_cnt(glitch_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: the pad is seen SYNC edges late; a run of DEB samples differing from the
   // committed level flips it, while a shorter run that ends counts as one glitch.
   logic [SYNC-1:0] m_sync;
   logic            m_level, m_rise, m_fall;
   int              m_run;
   logic [7:0]      m_gcnt;

   always @(posedge clk or negedge rst_n) begin : ref_model
      logic s, lvl, rs, fl, gl;
      int   run;
      if (!rst_n) begin
         m_sync  <= '0;
         m_level <= 1'b0;
         m_rise  <= 1'b0;
         m_fall  <= 1'b0;
         m_run   <= 0;
         m_gcnt  <= 8'd0;
      end else begin
         s   = m_sync[SYNC-1];
         lvl = m_level;
         run = m_run;
         rs  = 1'b0;
         fl  = 1'b0;
         gl  = 1'b0;
         if (s != lvl) begin
            run = run + 1;
            if (run == DEB) begin
               lvl = s;
               rs  = s;
               fl  = ~s;
               run = 0;
            end
         end else if (run > 0) begin
            gl  = 1'b1;
            run = 0;
         end
         m_level <= lvl;
         m_rise  <= rs;
         m_fall  <= fl;
         m_run   <= run;
         if (glitch_clr)            m_gcnt <= 8'd0;
         else if (gl && m_gcnt < 8'd255) m_gcnt <= m_gcnt + 8'd1;
         m_sync <= {m_sync[SYNC-2:0], pad_in};
      end
   end

   wire [10:0] dut_vec = {level_out, rise_pulse, fall_pulse, glitch_cnt};

   function automatic logic [10:0] exp_vec();
      return {m_level, m_rise, m_fall, m_gcnt};
   endfunction

   task automatic test_reset();
      pad_in     = 1'b0;
      glitch_clr = 1'b0;
      rst_n      = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (dut_vec !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_values dut=%h required=%h", dut_vec, 11'd0);
      end
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         n_tests++;
         if (dut_vec !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_hold t=%0t dut=%h required=%h", $time, dut_vec, 11'd0);
         end
         n_tests++;
         if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL model_reset t=%0t dut=%h model=%h", $time, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_rise();
      pad_in = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         @(negedge clk);
         n_tests++;
         if (level_out !== (e >= SYNC + DEB) || rise_pulse !== (e == SYNC + DEB) || fall_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_timing edge=%0d level=%b rise=%b fall=%b required level=%b rise=%b fall=0",
                     e, level_out, rise_pulse, fall_pulse, e >= SYNC + DEB, e == SYNC + DEB);
         end
         n_tests++;
         if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL model_rise t=%0t dut=%h model=%h", $time, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_fall();
      pad_in = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         @(negedge clk);
         n_tests++;
         if (level_out !== (e < SYNC + DEB) || fall_pulse !== (e == SYNC + DEB) || rise_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL fall_timing edge=%0d level=%b rise=%b fall=%b required level=%b rise=0 fall=%b",
                     e, level_out, rise_pulse, fall_pulse, e < SYNC + DEB, e == SYNC + DEB);
         end
         n_tests++;
         if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL model_fall t=%0t dut=%h model=%h", $time, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_glitch_low();
      for (int i = 0; i < 10; i++) begin
         pad_in = (i < 3);
         @(negedge clk);
         n_tests++;
         if (level_out !== 1'b0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_low_level t=%0t level=%b rise=%b fall=%b required 0/0/0",
                     $time, level_out, rise_pulse, fall_pulse);
         end
         n_tests++;
         if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL model_glitch_low t=%0t dut=%h model=%h", $time, dut_vec, exp_vec());
         end
      end
      n_tests++;
      if (glitch_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL glitch_low_count got=%0d required=1", glitch_cnt);
      end
   endtask

   task automatic test_saturation();
      for (int p = 0; p < 300; p++) begin
         int lo_len;
         lo_len = 3 + int'($urandom_range(0, 2));
         for (int i = 0; i < 3 + lo_len; i++) begin
            pad_in = (i < 3);
            @(negedge clk);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
               n_fail++;
               $display("FAIL model_sat t=%0t dut=%h model=%h", $time, dut_vec, exp_vec());
            end
         end
      end
      n_tests++;
      if (glitch_cnt !== 8'd255) begin
         n_fail++;
         $display("FAIL sat_count got=%0d required=255", glitch_cnt);
      end
      // Pad high at edges 1..3 reaches the FSM at edges 3..5; the glitch registers at edge 6.
      pad_in = 1'b1;
      repeat (3) @(negedge clk);
      pad_in = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (glitch_cnt !== 8'd255) begin
         n_fail++;
         $display("FAIL sat_hold got=%0d required=255", glitch_cnt);
      end
      glitch_clr = 1'b1;
      @(negedge clk);
      glitch_clr = 1'b0;
      n_tests++;
      if (glitch_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL clr_wins got=%0d required=0", glitch_cnt);
      end
      n_tests++;
      if (dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL model_clr t=%0t dut=%h model=%h", $time, dut_vec, exp_vec());
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_glitch_high();
      pad_in = 1'b1;
      repeat (8) @(negedge clk);
      n_tests++;
      if (level_out !== 1'b1) begin
         n_fail++;
         $display("FAIL high_setup level=%b required=1", level_out);
      end
      for (int i = 0; i < 10; i++) begin
         pad_in = !(i < 2);
         @(negedge clk);
         n_tests++;
         if (level_out !== 1'b1 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_high_level t=%0t level=%b rise=%b fall=%b required 1/0/0",
                     $time, level_out, rise_pulse, fall_pulse);
         end
         n_tests++;
         if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL model_glitch_high t=%0t dut=%h model=%h", $time, dut_vec, exp_vec());
         end
      end
      n_tests++;
      if (glitch_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL glitch_high_count got=%0d required=1", glitch_cnt);
      end
   endtask

   task automatic test_reset_in_chk();
      pad_in = 1'b0;
      repeat (10) @(negedge clk);
      pad_in = 1'b1;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (level_out !== 1'b0 || rise_pulse !== 1'b0 || glitch_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL chk_reset level=%b rise=%b gcnt=%0d required 0/0/0", level_out, rise_pulse, glitch_cnt);
      end
      repeat (3) begin
         @(negedge clk);
         n_tests++;
         if (dut_vec !== 11'd0) begin
            n_fail++;
            $display("FAIL chk_reset_hold dut=%h required=%h", dut_vec, 11'd0);
         end
      end
      rst_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         @(negedge clk);
         n_tests++;
         if (level_out !== (e >= SYNC + DEB) || rise_pulse !== (e == SYNC + DEB) || glitch_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL post_reset_rise edge=%0d level=%b rise=%b gcnt=%0d required level=%b rise=%b gcnt=0",
                     e, level_out, rise_pulse, glitch_cnt, e >= SYNC + DEB, e == SYNC + DEB);
         end
      end
   endtask

   task automatic test_random();
      int left;
      left = 0;
      for (int c = 0; c < 3000; c++) begin
         if (left == 0) begin
            pad_in = $urandom_range(0, 1);
            left   = int'($urandom_range(1, 8));
         end
         left--;
         glitch_clr = ($urandom_range(0, 49) == 0);
         @(negedge clk);
         n_tests++;
         if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL model_random t=%0t dut=%h model=%h", $time, dut_vec, exp_vec());
         end
         n_tests++;
         if (rise_pulse && fall_pulse) begin
            n_fail++;
            $display("FAIL strobe_excl t=%0t rise=%b fall=%b required not both", $time, rise_pulse, fall_pulse);
         end
      end
      glitch_clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_rise();
      test_fall();
      test_glitch_low();
      test_saturation();
      test_glitch_high();
      test_reset_in_chk();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
